dut_in_feeder: RTL and testbench
================================

Name: dut_in_feeder

Overview:
- Upstream stage that sources the 8-bit `data_in` stream of the `dut` core.
- Accepts bytes from a valid/ready producer (sequencer driver or upstream logic) and buffers them in a small FIFO.
- Drives them onto `data_in` one byte per beat, with a programmable idle gap between beats.
- Presents a defined idle value whenever no byte is being driven.

Parameters:
- DATA_W, 8: byte width; matches `dut` `data_in`.
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- GAP_W, 4: width of `gap_cfg`.
- IDLE_VAL, 8'h00: value driven on `data_in` when no beat is active.

Ports:
- clk  in  1  system clock; single domain.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  producer byte valid.
- s_ready  out  1  feeder can accept a byte.
- s_data  in  DATA_W  producer byte.
- enable  in  1  permits new beats to start.
- gap_cfg  in  GAP_W  idle cycles inserted after each beat; 0 = back-to-back.
- data_in  out  DATA_W  byte to `dut.data_in`; registered.
- data_in_vld  out  1  high during a driven beat; registered.
- fifo_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy.
- beat_cnt  out  16  beats issued since reset; wraps 16'hFFFF -> 0.

Behaviour:
- Reset: one clock, asynchronous active-low reset (`rst_n`), as already decided. While `rst_n`=0:
  - FIFO flushed: pointers and count = 0.
  - State = IDLE; gap counter = 0.
  - `data_in` = IDLE_VAL, `data_in_vld` = 0, `beat_cnt` = 0, `s_ready` = 1.
  - Reset mid-beat or mid-gap discards all buffered data; no partial beat after release.
- Push:
  - `s_ready` = (`fifo_cnt` < DEPTH), combinational from count only.
  - Push occurs when `s_valid` && `s_ready` at the rising edge.
  - When full, `s_ready`=0 even if a pop occurs in the same cycle (no full-bypass).
  - `s_data` must be held while `s_valid`=1 && `s_ready`=0.
- Pointers: wrap modulo DEPTH; the count disambiguates full from empty.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged.
- "Launch" (used below) = pop head into `data_in`, `data_in_vld`=1, `beat_cnt`+1, next state DRIVE.
- FSM states IDLE, DRIVE, GAP:
  - IDLE:
    - outputs `data_in`=IDLE_VAL, `data_in_vld`=0.
    - if `enable` && count>0: launch.
  - DRIVE: the beat lasts exactly 1 cycle. On its closing edge:
    - if `gap_cfg`>0: load gap counter with `gap_cfg` (sampled at this edge only), `data_in`=IDLE_VAL, `data_in_vld`=0, next state GAP.
    - else if `enable` && count>0: launch the next byte (back-to-back).
    - else: IDLE.
  - GAP:
    - outputs IDLE_VAL with `data_in_vld`=0 for exactly the sampled `gap_cfg` cycles; counter decrements each edge.
    - at the edge where the counter reaches 0: apply the IDLE evaluation (launch or IDLE).
    - `gap_cfg` changes during GAP have no effect on the gap in progress.
- Latency: byte pushed at edge N into an empty FIFO with FSM IDLE and `enable`=1 is on `data_in` after edge N+1 (1-cycle buffer latency).
- `enable` deasserted during DRIVE or GAP: the current beat and gap complete; no further launch until `enable`=1. Buffered bytes are retained.
- Empty FIFO at a launch point: go to IDLE; no underflow and no spurious `data_in_vld`.
- Byte order is strictly FIFO; no drop or duplication under any push/pop interleave.

Optional Feature:
- Macro: FEEDER_HOLD_LAST_EN.
- Defined: in IDLE and GAP, `data_in` holds the last driven byte instead of IDLE_VAL. `data_in_vld` behaviour is unchanged. After reset, `data_in` is IDLE_VAL until the first beat.
- Undefined: `data_in` = IDLE_VAL in every non-DRIVE cycle.

Decomposition:
- Package `dut_feeder_pkg`: FSM state enum (IDLE, DRIVE, GAP), default DATA_W / DEPTH / GAP_W localparams, IDLE_VAL default constant. The clock period stays in the existing `param.sv` `CLK_PERIOD` define.
- One sub-module: `dut_feeder_fifo` (synchronous FIFO, DEPTH x DATA_W, push/pop/count/full/empty). `dut_in_feeder` holds the FSM, gap counter and `beat_cnt`.

Test Plan:
- Reset: assert `rst_n`=0 mid-GAP with 3 bytes buffered, release -> `data_in`=8'h00, `data_in_vld`=0, `fifo_cnt`=0, `beat_cnt`=0, `s_ready`=1.
- Back-to-back: `gap_cfg`=0, `enable`=1, push A5, 5A, C3 on consecutive cycles -> `data_in` A5, 5A, C3 on 3 consecutive cycles, each 1 cycle after its push, `beat_cnt`=3.
- Gap: `gap_cfg`=2, push A5, 5A -> A5 (vld=1), two cycles 00 (vld=0), 5A (vld=1); change `gap_cfg` to 7 mid-gap -> gap still 2.
- Full/backpressure: `enable`=0, push 9 bytes 01..09 with `s_valid` held -> 8 accepted, `s_ready`=0 from the 8th accept; raise `enable` -> 01..08 output in order, then 09 after `s_ready` reasserts.
- Enable drop: `enable`=1, 4 bytes buffered, drop `enable` during the 2nd beat -> exactly 2 beats emitted, `fifo_cnt`=2 retained; re-enable -> remaining 2 bytes in order.
- FEEDER_HOLD_LAST_EN build: push 3C, `gap_cfg`=3 -> `data_in` stays 3C with vld=0 through the gap and idle; non-macro build shows 00.

Source files
------------

// File: rtl/dut_feeder_pkg.sv
// Shared types and default parameters for the dut_in_feeder slice.
// FSM state encoding and default widths/idle value live here so the FIFO, interface and top agree.
package dut_feeder_pkg;

  localparam int         DEF_DATA_W   = 8;
  localparam int         DEF_DEPTH    = 8;
  localparam int         DEF_GAP_W    = 4;
  localparam logic [7:0] DEF_IDLE_VAL = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/dut_in_feeder_if.sv
// Producer-side valid/ready bus plus the registered byte stream towards dut.data_in.
// master = producer/consumer test side, slave = the feeder itself.
interface dut_in_feeder_if
  import dut_feeder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [DATA_W-1:0] data_in;
  logic              data_in_vld;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  data_in,
    input  data_in_vld
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output data_in,
    output data_in_vld
  );

endinterface

// File: rtl/dut_feeder_fifo.sv
// Synchronous DEPTH x DATA_W FIFO with show-ahead head output.
// Pointers wrap modulo DEPTH (power of two); the occupancy count separates full from empty.
module dut_feeder_fifo
  import dut_feeder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [DATA_W-1:0]      i_wdata,
  input  logic                   i_pop,
  output logic [DATA_W-1:0]      o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              w_doPush;
  logic              w_doPop;

  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rdPtr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/dut_in_feeder.sv
// Buffers producer bytes and issues them onto dut.data_in one beat at a time with a programmable gap.
// Build option FEEDER_HOLD_LAST_EN: data_in holds the last driven byte outside beats instead of IDLE_VAL.
module dut_in_feeder
  import dut_feeder_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter int                GAP_W    = DEF_GAP_W,
  parameter logic [DATA_W-1:0] IDLE_VAL = DATA_W'(DEF_IDLE_VAL)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dut_in_feeder_if.slave         bus,
  input  logic                   enable,
  input  logic [GAP_W-1:0]       gap_cfg,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic [15:0]            beat_cnt
);

  feeder_state_e     r_state;
  logic [GAP_W-1:0]  r_gapCnt;
  logic [DATA_W-1:0] r_dataIn;
  logic              r_dataVld;
  logic [15:0]       r_beatCnt;

  logic [DATA_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_canLaunch;
  logic              w_launch;

  // s_ready depends on occupancy only, so a same-cycle pop never opens a full FIFO
  assign bus.s_ready = !w_full;
  assign w_push      = bus.s_valid && !w_full;
  assign w_canLaunch = enable && !w_empty;

  dut_feeder_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (bus.s_data),
    .i_pop   (w_launch),
    .o_rdata (w_head),
    .o_count (fifo_cnt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_launch = 1'b0;
    case (r_state)
      ST_IDLE:  w_launch = w_canLaunch;
      ST_DRIVE: w_launch = (gap_cfg == '0) && w_canLaunch;
      ST_GAP:   w_launch = (r_gapCnt == GAP_W'(1)) && w_canLaunch;
      default:  w_launch = 1'b0;
    endcase
  end

  // A launch below overrides whatever the state case chose for this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gapCnt  <= '0;
      r_dataIn  <= IDLE_VAL;
      r_dataVld <= 1'b0;
      r_beatCnt <= '0;
    end else begin
      r_dataVld <= 1'b0;
`ifdef FEEDER_HOLD_LAST_EN
      r_dataIn  <= r_dataIn;
`else
      r_dataIn  <= IDLE_VAL;
`endif
      case (r_state)
        ST_DRIVE: begin
          if (gap_cfg != '0) begin
            r_gapCnt <= gap_cfg;
            r_state  <= ST_GAP;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_GAP: begin
          r_gapCnt <= r_gapCnt - GAP_W'(1);
          if (r_gapCnt == GAP_W'(1)) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_launch) begin
        r_dataIn  <= w_head;
        r_dataVld <= 1'b1;
        r_beatCnt <= r_beatCnt + 16'd1;
        r_state   <= ST_DRIVE;
      end
    end
  end

  assign bus.data_in     = r_dataIn;
  assign bus.data_in_vld = r_dataVld;
  assign beat_cnt        = r_beatCnt;

endmodule

// File: tb/tb_dut_in_feeder.sv
// Directed self-checking bench for dut_in_feeder; expected idle byte follows FEEDER_HOLD_LAST_EN.
module tb_dut_in_feeder;
  import dut_feeder_pkg::*;

  localparam int CLK_HALF = 5;
  localparam bit HOLD =
`ifdef FEEDER_HOLD_LAST_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  gap_cfg = 4'd0;
  logic [3:0]  fifo_cnt;
  logic [15:0] beat_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  beats[$];
  logic [15:0] expBeats = 16'd0;

  dut_in_feeder_if #(.DATA_W(8)) bus ();

  dut_in_feeder #(
    .DATA_W   (8),
    .DEPTH    (8),
    .GAP_W    (4),
    .IDLE_VAL (8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .enable   (enable),
    .gap_cfg  (gap_cfg),
    .fifo_cnt (fifo_cnt),
    .beat_cnt (beat_cnt)
  );

  always #CLK_HALF clk = ~clk;

  // Records every driven beat so ordering tests can compare whole sequences
  always @(negedge clk) begin
    if (rst_n && bus.data_in_vld) beats.push_back(bus.data_in);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] idleOf(input logic [7:0] last);
    return HOLD ? last : 8'h00;
  endfunction

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] pre [4];
    pre[0] = 8'h11; pre[1] = 8'h22; pre[2] = 8'h33; pre[3] = 8'h44;
    enable = 1'b0;
    gap_cfg = 4'd5;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s_data = pre[i];
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    enable = 1'b1;
    cyc(3);
    checks++;
    if (fifo_cnt !== 4'd3 || beat_cnt !== 16'd1 || bus.data_in_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pre_reset got cnt=%0d beats=%0d vld=%b exp cnt=3 beats=1 vld=0", fifo_cnt, beat_cnt, bus.data_in_vld);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.data_in !== 8'h00) begin errors++; $display("[TB] FAIL rst_data got %h exp 00", bus.data_in); end
    checks++;
    if (bus.data_in_vld !== 1'b0) begin errors++; $display("[TB] FAIL rst_vld got %b exp 0", bus.data_in_vld); end
    checks++;
    if (fifo_cnt !== 4'd0) begin errors++; $display("[TB] FAIL rst_fifo_cnt got %0d exp 0", fifo_cnt); end
    checks++;
    if (beat_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rst_beat_cnt got %0d exp 0", beat_cnt); end
    checks++;
    if (bus.s_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_s_ready got %b exp 1", bus.s_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b0;
    gap_cfg = 4'd0;
    cyc(2);
    beats.delete();
    enable = 1'b1;
    cyc(6);
    checks++;
    if (beats.size() != 0 || fifo_cnt !== 4'd0 || bus.data_in !== 8'h00) begin
      errors++;
      $display("[TB] FAIL post_reset_flush got beats=%0d cnt=%0d data=%h exp 0 0 00", beats.size(), fifo_cnt, bus.data_in);
    end
    expBeats = 16'd0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] pushData [5];
    logic       pushVld  [5];
    logic [7:0] expData  [5];
    logic       expVld   [5];
    pushData[0] = 8'hA5; pushData[1] = 8'h5A; pushData[2] = 8'hC3; pushData[3] = 8'h00; pushData[4] = 8'h00;
    pushVld[0] = 1; pushVld[1] = 1; pushVld[2] = 1; pushVld[3] = 0; pushVld[4] = 0;
    expData[0] = 8'h00; expData[1] = 8'hA5; expData[2] = 8'h5A; expData[3] = 8'hC3; expData[4] = idleOf(8'hC3);
    expVld[0] = 0; expVld[1] = 1; expVld[2] = 1; expVld[3] = 1; expVld[4] = 0;
    gap_cfg = 4'd0;
    enable = 1'b1;
    bus.s_valid = pushVld[0];
    bus.s_data = pushData[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.data_in_vld !== expVld[i] || bus.data_in !== expData[i]) begin
        errors++;
        $display("[TB] FAIL b2b_cycle%0d got data=%h vld=%b exp data=%h vld=%b", i, bus.data_in, bus.data_in_vld, expData[i], expVld[i]);
      end
      if (i < 4) begin
        bus.s_valid = pushVld[i+1];
        bus.s_data = pushData[i+1];
      end
    end
    expBeats = expBeats + 16'd3;
    checks++;
    if (beat_cnt !== expBeats) begin errors++; $display("[TB] FAIL b2b_beat_cnt got %0d exp %0d", beat_cnt, expBeats); end
  endtask

  task automatic test_gap();
    logic [7:0] expData [6];
    logic       expVld  [6];
    expData[0] = idleOf(8'hC3); expData[1] = 8'hA5; expData[2] = idleOf(8'hA5);
    expData[3] = idleOf(8'hA5); expData[4] = 8'h5A; expData[5] = idleOf(8'h5A);
    expVld[0] = 0; expVld[1] = 1; expVld[2] = 0; expVld[3] = 0; expVld[4] = 1; expVld[5] = 0;
    gap_cfg = 4'd2;
    enable = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.data_in_vld !== expVld[i] || bus.data_in !== expData[i]) begin
        errors++;
        $display("[TB] FAIL gap_cycle%0d got data=%h vld=%b exp data=%h vld=%b", i, bus.data_in, bus.data_in_vld, expData[i], expVld[i]);
      end
      if (i == 0) bus.s_data = 8'h5A;
      if (i == 1) bus.s_valid = 1'b0;
      if (i == 2) gap_cfg = 4'd7;
    end
    gap_cfg = 4'd0;
    cyc(10);
    expBeats = expBeats + 16'd2;
    checks++;
    if (beat_cnt !== expBeats) begin errors++; $display("[TB] FAIL gap_beat_cnt got %0d exp %0d", beat_cnt, expBeats); end
  endtask

  task automatic test_full();
    int   accepted = 0;
    logic rdy;
    logic got = 1'b0;
    logic orderOk = 1'b1;
    enable = 1'b0;
    gap_cfg = 4'd0;
    beats.delete();
    bus.s_valid = 1'b1;
    bus.s_data = 8'h01;
    for (int c = 0; c < 12 && accepted < 8; c++) begin
      rdy = bus.s_ready;
      @(negedge clk);
      if (rdy) begin
        accepted++;
        bus.s_data = 8'(accepted + 1);
      end
    end
    checks++;
    if (accepted != 8 || fifo_cnt !== 4'd8) begin
      errors++;
      $display("[TB] FAIL full_accept got acc=%0d cnt=%0d exp 8 8", accepted, fifo_cnt);
    end
    checks++;
    if (bus.s_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_s_ready got %b exp 0", bus.s_ready); end
    @(negedge clk);
    checks++;
    if (fifo_cnt !== 4'd8) begin errors++; $display("[TB] FAIL full_hold_cnt got %0d exp 8", fifo_cnt); end
    enable = 1'b1;
    #1;
    checks++;
    if (bus.s_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_no_bypass got %b exp 0", bus.s_ready); end
    for (int c = 0; c < 10 && !got; c++) begin
      rdy = bus.s_ready;
      @(negedge clk);
      if (rdy) got = 1'b1;
    end
    bus.s_valid = 1'b0;
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL full_ninth_accept got 0 exp 1"); end
    cyc(15);
    checks++;
    if (beats.size() != 9) begin errors++; $display("[TB] FAIL full_beat_count got %0d exp 9", beats.size()); end
    for (int i = 0; i < beats.size() && i < 9; i++) begin
      if (beats[i] !== 8'(i + 1)) orderOk = 1'b0;
    end
    checks++;
    if (!orderOk) begin errors++; $display("[TB] FAIL full_order got first=%h exp 01..09 in order", beats[0]); end
    expBeats = expBeats + 16'd9;
    checks++;
    if (beat_cnt !== expBeats) begin errors++; $display("[TB] FAIL full_beat_cnt got %0d exp %0d", beat_cnt, expBeats); end
  endtask

  task automatic test_enable_drop();
    logic [7:0] src [4];
    logic       orderOk = 1'b1;
    src[0] = 8'hB1; src[1] = 8'hB2; src[2] = 8'hB3; src[3] = 8'hB4;
    enable = 1'b0;
    gap_cfg = 4'd0;
    beats.delete();
    bus.s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s_data = src[i];
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.data_in !== 8'hB1 || bus.data_in_vld !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drop_beat1 got %h/%b exp b1/1", bus.data_in, bus.data_in_vld);
    end
    @(negedge clk);
    checks++;
    if (bus.data_in !== 8'hB2 || bus.data_in_vld !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drop_beat2 got %h/%b exp b2/1", bus.data_in, bus.data_in_vld);
    end
    enable = 1'b0;
    cyc(5);
    checks++;
    if (beats.size() != 2 || fifo_cnt !== 4'd2) begin
      errors++;
      $display("[TB] FAIL drop_retain got beats=%0d cnt=%0d exp 2 2", beats.size(), fifo_cnt);
    end
    enable = 1'b1;
    cyc(6);
    checks++;
    if (beats.size() != 4) begin errors++; $display("[TB] FAIL drop_total got %0d exp 4", beats.size()); end
    for (int i = 0; i < beats.size() && i < 4; i++) begin
      if (beats[i] !== src[i]) orderOk = 1'b0;
    end
    checks++;
    if (!orderOk) begin errors++; $display("[TB] FAIL drop_order got first=%h exp b1..b4 in order", beats[0]); end
    expBeats = expBeats + 16'd4;
    checks++;
    if (beat_cnt !== expBeats) begin errors++; $display("[TB] FAIL drop_beat_cnt got %0d exp %0d", beat_cnt, expBeats); end
  endtask

  task automatic test_hold();
    enable = 1'b1;
    gap_cfg = 4'd3;
    bus.s_valid = 1'b1;
    bus.s_data = 8'h3C;
    @(negedge clk);
    bus.s_valid = 1'b0;
    checks++;
    if (bus.data_in !== idleOf(8'hB4) || bus.data_in_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_pre got %h/%b exp %h/0", bus.data_in, bus.data_in_vld, idleOf(8'hB4));
    end
    @(negedge clk);
    checks++;
    if (bus.data_in !== 8'h3C || bus.data_in_vld !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_beat got %h/%b exp 3c/1", bus.data_in, bus.data_in_vld);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.data_in !== idleOf(8'h3C) || bus.data_in_vld !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_idle%0d got %h/%b exp %h/0", i, bus.data_in, bus.data_in_vld, idleOf(8'h3C));
      end
    end
    expBeats = expBeats + 16'd1;
    checks++;
    if (beat_cnt !== expBeats) begin errors++; $display("[TB] FAIL hold_beat_cnt got %0d exp %0d", beat_cnt, expBeats); end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    $display("[TB] starting, hold-last build = %0d", HOLD);
    test_reset();
    test_back_to_back();
    test_gap();
    test_full();
    test_enable_drop();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
